// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl
//   Framed command controller sitting between a UART receiver, an ALU and a
//   UART transmitter. A frame is SYNC, opcode, operand A (NBYTES, LSB first),
//   operand B (NBYTES, LSB first) and, when CHK_EN=1, an XOR checksum of the
//   opcode and operand bytes. The response is a status byte (00 ok, E1 bad
//   checksum, E2 inter-byte timeout) followed, on success only, by the
//   NBYTES-wide ALU result, LSB first.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   rx_done_tick/rx_data received byte strobe and value
//   tx_done_tick        transmitter finished the outstanding byte
//   tx_start/tx_data    start pulse and byte for the transmitter
//   alu_a/alu_b/alu_op  ALU operands and opcode, loaded together on EXEC entry
//   alu_result          ALU output, valid ALU_LAT cycles after the operands
//   busy                high whenever not IDLE
//   overrun             one-cycle pulse when a received byte is dropped
//
// state       | meaning
// ST_IDLE     | waiting for SYNC, other bytes ignored
// ST_OP       | waiting for opcode byte
// ST_A        | shifting in operand A bytes
// ST_B        | shifting in operand B bytes
// ST_CHK      | waiting for checksum byte
// ST_EXEC     | operands on the ALU, waiting ALU_LAT cycles
// ST_TX_STAT  | status byte handed to transmitter (tx_start high)
// ST_TX_WAIT  | waiting for status byte to finish
// ST_TX_RES   | result byte handed to transmitter (tx_start high)
// ST_TX_RWAIT | waiting for result byte to finish
module uart_alu_frame_ctrl #(
    parameter int         NBYTES  = 2,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter bit         CHK_EN  = 1'b1,
    parameter int         TIMEOUT = 100000,
    parameter int         ALU_LAT = 1,
    localparam int        DATA_W  = 8 * NBYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              overrun
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT);

    localparam logic [7:0] STAT_OK  = 8'h00;
    localparam logic [7:0] STAT_CHK = 8'hE1;
    localparam logic [7:0] STAT_TO  = 8'hE2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OP,
        ST_A,
        ST_B,
        ST_CHK,
        ST_EXEC,
        ST_TX_STAT,
        ST_TX_WAIT,
        ST_TX_RES,
        ST_TX_RWAIT
    } state_t;

    state_t state, next_state;

    logic [5:0]        op_hold;
    logic [DATA_W-1:0] a_hold, b_hold, b_final;
    logic [DATA_W-1:0] res_q;
    logic [7:0]        chk_q;
    logic [7:0]        status_q, status_next;
    logic [TO_W-1:0]   to_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic              in_frame, to_hit, last_byte, tx_phase;

    // New byte enters at the top; after NBYTES bytes the first one is the LSB.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r,
                                                   input logic [7:0] b);
        return DATA_W'({b, r} >> 8);
    endfunction

    assign in_frame  = (state inside {ST_OP, ST_A, ST_B, ST_CHK});
    assign tx_phase  = (state inside {ST_EXEC, ST_TX_STAT, ST_TX_WAIT, ST_TX_RES, ST_TX_RWAIT});
    assign to_hit    = in_frame && (to_cnt == TO_MAX);
    assign last_byte = (byte_idx == LAST_IDX);
    assign busy      = (state != ST_IDLE);

    // Without a checksum byte EXEC is entered on the last B byte, before
    // b_hold has absorbed it, so the operand load takes the shifted value.
    assign b_final = (state == ST_B && rx_done_tick) ? shift_in(b_hold, rx_data) : b_hold;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        status_next = status_q;
        case (state)
            ST_IDLE: begin
                if (rx_done_tick && rx_data == SYNC) next_state = ST_OP;
            end
            ST_OP: begin
                if (rx_done_tick) next_state = ST_A;
                else if (to_hit) begin
                    next_state  = ST_TX_STAT;
                    status_next = STAT_TO;
                end
            end
            ST_A: begin
                if (rx_done_tick) begin
                    if (last_byte) next_state = ST_B;
                end else if (to_hit) begin
                    next_state  = ST_TX_STAT;
                    status_next = STAT_TO;
                end
            end
            ST_B: begin
                if (rx_done_tick) begin
                    if (last_byte) next_state = CHK_EN ? ST_CHK : ST_EXEC;
                end else if (to_hit) begin
                    next_state  = ST_TX_STAT;
                    status_next = STAT_TO;
                end
            end
            ST_CHK: begin
                if (rx_done_tick) begin
                    if (rx_data == chk_q) next_state = ST_EXEC;
                    else begin
                        next_state  = ST_TX_STAT;
                        status_next = STAT_CHK;
                    end
                end else if (to_hit) begin
                    next_state  = ST_TX_STAT;
                    status_next = STAT_TO;
                end
            end
            ST_EXEC: begin
                if (lat_cnt == '0) begin
                    next_state  = ST_TX_STAT;
                    status_next = STAT_OK;
                end
            end
            ST_TX_STAT: next_state = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (tx_done_tick) next_state = (status_q == STAT_OK) ? ST_TX_RES : ST_IDLE;
            end
            ST_TX_RES: next_state = ST_TX_RWAIT;
            ST_TX_RWAIT: begin
                if (tx_done_tick) next_state = last_byte ? ST_IDLE : ST_TX_RES;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            overrun  <= 1'b0;
            op_hold  <= '0;
            a_hold   <= '0;
            b_hold   <= '0;
            res_q    <= '0;
            chk_q    <= '0;
            status_q <= '0;
            to_cnt   <= '0;
            byte_idx <= '0;
            lat_cnt  <= '0;
        end else begin
            // tx_start is high exactly during the ST_TX_STAT / ST_TX_RES cycles.
            tx_start <= (next_state == ST_TX_STAT) || (next_state == ST_TX_RES);
            overrun  <= rx_done_tick && tx_phase;
            to_cnt   <= (in_frame && !rx_done_tick) ? to_cnt + 1'b1 : '0;

            case (state)
                ST_IDLE: begin
                    if (rx_done_tick && rx_data == SYNC) begin
                        chk_q    <= '0;
                        byte_idx <= '0;
                    end
                end
                ST_OP: begin
                    if (rx_done_tick) begin
                        op_hold <= rx_data[5:0];
                        chk_q   <= chk_q ^ rx_data;
                    end
                end
                ST_A: begin
                    if (rx_done_tick) begin
                        a_hold   <= shift_in(a_hold, rx_data);
                        chk_q    <= chk_q ^ rx_data;
                        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                    end
                end
                ST_B: begin
                    if (rx_done_tick) begin
                        b_hold   <= b_final;
                        chk_q    <= chk_q ^ rx_data;
                        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                    else               res_q   <= alu_result;
                end
                ST_TX_WAIT: begin
                    if (tx_done_tick) byte_idx <= '0;
                end
                ST_TX_RWAIT: begin
                    if (tx_done_tick && !last_byte) byte_idx <= byte_idx + 1'b1;
                end
                default: ;
            endcase

            if (next_state == ST_EXEC && state != ST_EXEC) begin
                alu_a   <= a_hold;
                alu_b   <= b_final;
                alu_op  <= op_hold;
                lat_cnt <= LAT_LOAD;
            end

            if (next_state == ST_TX_STAT) begin
                tx_data  <= status_next;
                status_q <= status_next;
            end

            if (next_state == ST_TX_RES) begin
                tx_data <= res_q[7:0];
                res_q   <= res_q >> 8;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed bench for uart_alu_frame_ctrl. Instance 0: NBYTES=2, CHK_EN=1,
// TIMEOUT=50. Instance 1: NBYTES=4, CHK_EN=0. A registered ALU model
// (op 20 ADD, op 22 SUB) and a transmitter model with fixed byte time
// surround each instance.
module tb_uart_alu_frame_ctrl;

    localparam int TO     = 50;
    localparam int TX_DLY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_tick   [2];
    logic [7:0]  rx_dat    [2];
    logic        tx_done_s [2];
    logic        tx_start_s[2];
    logic [7:0]  tx_dat    [2];
    logic        busy_s    [2];
    logic        ovr_s     [2];

    logic [15:0] a0, b0, r0;
    logic [5:0]  op0;
    logic [31:0] a1, b1, r1;
    logic [5:0]  op1;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_rx_cyc = 0;
    logic [7:0]  tx_log [2][16];
    int          tx_cyc [2][16];
    int          tx_n   [2];
    bit          pending[2];
    int          tx_cnt [2];
    int          overlap[2];
    int          ovr_cnt[2];
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    uart_alu_frame_ctrl #(.NBYTES(2), .SYNC(8'hA5), .CHK_EN(1'b1), .TIMEOUT(TO), .ALU_LAT(1)) dut0 (
        .clk(clk), .reset(reset),
        .rx_done_tick(rx_tick[0]), .rx_data(rx_dat[0]),
        .tx_done_tick(tx_done_s[0]), .tx_start(tx_start_s[0]), .tx_data(tx_dat[0]),
        .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_result(r0),
        .busy(busy_s[0]), .overrun(ovr_s[0])
    );

    uart_alu_frame_ctrl #(.NBYTES(4), .SYNC(8'hA5), .CHK_EN(1'b0), .TIMEOUT(TO), .ALU_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .rx_done_tick(rx_tick[1]), .rx_data(rx_dat[1]),
        .tx_done_tick(tx_done_s[1]), .tx_start(tx_start_s[1]), .tx_data(tx_dat[1]),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(r1),
        .busy(busy_s[1]), .overrun(ovr_s[1])
    );

    // ALU with one cycle of latency
    always @(posedge clk) begin
        r0 <= (op0 == 6'h22) ? a0 - b0 : a0 + b0;
        r1 <= (op1 == 6'h22) ? a1 - b1 : a1 + b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model and overrun monitor, sampled on the falling edge
    initial begin
        for (int d = 0; d < 2; d++) begin
            tx_done_s[d] = 1'b0;
            tx_n[d] = 0; pending[d] = 1'b0; tx_cnt[d] = 0;
            overlap[d] = 0; ovr_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                tx_done_s[d] = 1'b0;
                if (ovr_s[d] === 1'b1) ovr_cnt[d]++;
                if (tx_start_s[d] === 1'b1) begin
                    if (pending[d]) overlap[d]++;
                    if (tx_n[d] < 16) begin
                        tx_log[d][tx_n[d]] = tx_dat[d];
                        tx_cyc[d][tx_n[d]] = cyc;
                    end
                    tx_n[d]++;
                    pending[d] = 1'b1;
                    tx_cnt[d] = TX_DLY;
                end else if (pending[d]) begin
                    tx_cnt[d]--;
                    if (tx_cnt[d] == 0) begin
                        tx_done_s[d] = 1'b1;
                        pending[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [7:0] b);
        rx_dat[d]  = b;
        rx_tick[d] = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_tick[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input int d);
        foreach (frame_q[i]) send(d, frame_q[i]);
    endtask

    task automatic wait_idle(input int d, input int n, input string tag);
        int k = 0;
        while (!(tx_n[d] >= n && !pending[d] && busy_s[d] === 1'b0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(k < 400), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_tx(input int d, input string tag);
        chk({tag, "_count"}, 32'(tx_n[d]), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < 16; i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, tx_log[d][i]}, {24'h0, exp_q[i]});
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rx_tick[d] = 1'b0;
            rx_dat[d]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_tx_start", {31'h0, tx_start_s[0]}, 32'd0);
        chk("rst_tx_data",  {24'h0, tx_dat[0]},     32'd0);
        chk("rst_alu_a",    {16'h0, a0},            32'd0);
        chk("rst_alu_b",    {16'h0, b0},            32'd0);
        chk("rst_alu_op",   {26'h0, op0},           32'd0);
        chk("rst_busy",     {31'h0, busy_s[0]},     32'd0);
        chk("rst_overrun",  {31'h0, ovr_s[0]},      32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Good ADD frame
        tx_n[0] = 0;
        frame_q = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
        send_frame(0);
        chk("ok_busy_during", {31'h0, busy_s[0]}, 32'd1);
        wait_idle(0, 3, "ok");
        exp_q = '{8'h00, 8'h35, 8'h12};
        chk_tx(0, "ok_tx");
        chk("ok_latency", 32'(tx_cyc[0][0] - last_rx_cyc), 32'd3);
        chk("ok_alu_a",  {16'h0, a0}, 32'h1234);
        chk("ok_alu_b",  {16'h0, b0}, 32'h0001);
        chk("ok_alu_op", {26'h0, op0}, 32'h20);
        chk("ok_busy_after", {31'h0, busy_s[0]}, 32'd0);

        // Same frame, wrong checksum
        tx_n[0] = 0;
        frame_q = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h08};
        send_frame(0);
        wait_idle(0, 1, "badchk");
        exp_q = '{8'hE1};
        chk_tx(0, "badchk_tx");
        chk("badchk_latency", 32'(tx_cyc[0][0] - last_rx_cyc), 32'd1);

        // Different operands, wrong checksum (correct would be 20): ALU inputs untouched
        tx_n[0] = 0;
        frame_q = '{8'hA5, 8'h20, 8'h11, 8'h11, 8'h22, 8'h22, 8'h21};
        send_frame(0);
        wait_idle(0, 1, "badchk2");
        exp_q = '{8'hE1};
        chk_tx(0, "badchk2_tx");
        chk("badchk2_alu_a", {16'h0, a0}, 32'h1234);
        chk("badchk2_alu_b", {16'h0, b0}, 32'h0001);
        chk("badchk2_busy",  {31'h0, busy_s[0]}, 32'd0);

        // Inter-byte timeout, then a good frame
        tx_n[0] = 0;
        frame_q = '{8'hA5, 8'h20, 8'h34};
        send_frame(0);
        wait_idle(0, 1, "to");
        repeat (TO + 10) @(negedge clk);
        exp_q = '{8'hE2};
        chk_tx(0, "to_tx");
        chk("to_latency_window",
            32'((tx_cyc[0][0] - last_rx_cyc >= TO) && (tx_cyc[0][0] - last_rx_cyc <= TO + 2)), 32'd1);
        tx_n[0] = 0;
        frame_q = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
        send_frame(0);
        wait_idle(0, 3, "after_to");
        exp_q = '{8'h00, 8'h35, 8'h12};
        chk_tx(0, "after_to_tx");

        // Junk before SYNC is ignored silently
        tx_n[0] = 0;
        ovr_cnt[0] = 0;
        frame_q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
        send_frame(0);
        wait_idle(0, 3, "junk");
        chk_tx(0, "junk_tx");
        chk("junk_overrun", 32'(ovr_cnt[0]), 32'd0);

        // Byte arriving during result transmission is dropped
        tx_n[0] = 0;
        ovr_cnt[0] = 0;
        frame_q = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
        send_frame(0);
        begin
            int k = 0;
            while (tx_n[0] < 2 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("ovr_reach_result", 32'(k < 200), 32'd1);
        end
        send(0, 8'h55);
        wait_idle(0, 3, "ovr");
        chk_tx(0, "ovr_tx");
        chk("ovr_pulses", 32'(ovr_cnt[0]), 32'd1);

        // Reset mid-frame
        tx_n[0] = 0;
        frame_q = '{8'hA5, 8'h20, 8'h34};
        send_frame(0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx_start", {31'h0, tx_start_s[0]}, 32'd0);
        chk("midrst_tx_data",  {24'h0, tx_dat[0]},     32'd0);
        chk("midrst_alu_a",    {16'h0, a0},            32'd0);
        chk("midrst_alu_b",    {16'h0, b0},            32'd0);
        chk("midrst_alu_op",   {26'h0, op0},           32'd0);
        chk("midrst_busy",     {31'h0, busy_s[0]},     32'd0);
        reset = 1'b0;
        repeat (TO + 20) @(negedge clk);
        chk("midrst_no_tx", 32'(tx_n[0]), 32'd0);
        frame_q = '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
        send_frame(0);
        wait_idle(0, 3, "postrst");
        exp_q = '{8'h00, 8'h35, 8'h12};
        chk_tx(0, "postrst_tx");
        chk("postrst_alu_a", {16'h0, a0}, 32'h1234);

        // 4-byte instance, no checksum, SUB 80000000 - FFFFFFFF
        tx_n[1] = 0;
        frame_q = '{8'hA5, 8'h22, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(1);
        wait_idle(1, 5, "w4");
        exp_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h80};
        chk_tx(1, "w4_tx");
        chk("w4_latency", 32'(tx_cyc[1][0] - last_rx_cyc), 32'd3);
        chk("w4_alu_a",  a1, 32'h80000000);
        chk("w4_alu_b",  b1, 32'hFFFFFFFF);
        chk("w4_alu_op", {26'h0, op1}, 32'h22);

        chk("no_tx_overlap_0", 32'(overlap[0]), 32'd0);
        chk("no_tx_overlap_1", 32'(overlap[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
- Framed, multi-byte command controller between the UART receiver and transmitter of the UART/ALU design.
- Replaces the fixed three-byte receive interface and single-byte transmit interface with one parametrised block.
- Assembles a command frame (sync byte, opcode, two NBYTES-wide operands, optional XOR checksum), drives the ALU, waits ALU_LAT cycles, then returns a status byte plus the NBYTES-wide result, least-significant byte first.
- Detects bad checksums, inter-byte timeouts and receive overruns.

Parameters:
- NBYTES, 2: bytes per operand/result; DATA_W = 8*NBYTES.
- SYNC, 8'hA5: frame start byte.
- CHK_EN, 1: 1 = checksum byte expected and verified; 0 = no checksum byte.
- TIMEOUT, 100000: max clk cycles between consecutive bytes inside a frame.
- ALU_LAT, 1: clk cycles from operands stable to alu_result valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle pulse; rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_done_tick  in  1  one-cycle pulse; transmitter has finished the current byte.
- tx_start  out  1  one-cycle pulse; starts transmission of tx_data.
- tx_data  out  8  byte to transmit; held stable until tx_done_tick.
- alu_a  out  DATA_W  operand A (signed).
- alu_b  out  DATA_W  operand B (signed).
- alu_op  out  6  ALU opcode (low 6 bits of opcode byte).
- alu_result  in  DATA_W  ALU output.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when a received byte is dropped.

Behaviour:
- Reset values: state IDLE; tx_start=0, tx_data=0, alu_a=0, alu_b=0, alu_op=0, busy=0, overrun=0; byte counter, checksum and timeout counter = 0.
- Reset mid-frame or mid-transmit: returns to IDLE on the next edge with no further tx_start. A byte already handed to the transmitter is allowed to finish.
- IDLE:
  - rx_done_tick with rx_data==SYNC -> OP; clear checksum and timeout counter.
  - Any other byte is discarded silently; no overrun.
- OP: byte -> alu_op holding register; checksum ^= byte -> A.
- A: NBYTES bytes, LSB first, shifted into the A register; checksum ^= each byte. After the last byte -> B.
- B: same as A into the B register. After the last byte -> CHK if CHK_EN, else EXEC.
- CHK: received byte compared with the running checksum.
  - Equal -> EXEC.
  - Not equal -> TX_STATUS with status 8'hE1; no result bytes follow.
- Operand visibility: alu_a, alu_b and alu_op update only on entry to EXEC, as one simultaneous load from the holding registers. ALU inputs never show partial operands.
- EXEC: waits ALU_LAT cycles, captures alu_result into the result register, then TX_STATUS with status 8'h00.
- Timeout:
  - In OP, A, B and CHK the timeout counter increments every cycle and clears on each rx_done_tick.
  - Reaching TIMEOUT -> TX_STATUS with status 8'hE2.
  - The counter is idle in all other states.
- TX_STATUS: tx_data <= status, tx_start pulses for 1 cycle -> TX_WAIT.
- TX_WAIT on tx_done_tick:
  - Status 00 -> TX_RES with byte index 0.
  - Otherwise -> IDLE.
- TX_RES: tx_data <= result byte[index], tx_start pulse -> TX_RES_WAIT.
- TX_RES_WAIT on tx_done_tick:
  - index==NBYTES-1 -> IDLE.
  - Otherwise index+1 -> TX_RES.
- tx_start is never asserted while a byte is outstanding, i.e. between a tx_start pulse and its tx_done_tick.
- Overrun: rx_done_tick in EXEC, TX_STATUS, TX_WAIT, TX_RES or TX_RES_WAIT -> byte dropped, overrun pulses 1 cycle, state unaffected.
- rx_done_tick and tx_done_tick in the same cycle: both are handled under the rules above; neither is lost.
- Latency: the first tx_start follows the final frame byte's rx_done_tick by ALU_LAT+2 cycles (OK path) or 1 cycle (checksum error).
- A SYNC value appearing inside a frame is treated as data.

Test Plan:
- NBYTES=2, CHK_EN=1, ALU model ADD (op 6'h20). Rx A5 20 34 12 01 00 07 with alu_result=A+B -> alu_a=16'h1234, alu_b=16'h0001, alu_op=6'h20; tx sequence 00 35 12; busy low afterwards.
- Same frame with checksum byte 08 -> tx sequence E1 only; alu_a/alu_b keep their previous values; returns to IDLE.
- Rx A5 20 34, then idle for TIMEOUT cycles (TIMEOUT=50) -> tx E2 exactly once; a following valid frame completes normally.
- Junk bytes 00 FF 12 before A5 20 34 12 01 00 07 -> junk ignored, overrun stays 0, response 00 35 12.
- Inject rx byte 55 while the result bytes are transmitting -> overrun pulses 1 cycle, tx sequence unchanged.
- Reset asserted after rx A5 20 34 -> all outputs at reset values; no tx_start; next full frame answered correctly. Also run NBYTES=4, CHK_EN=0 with A=32'h80000000, B=32'hFFFFFFFF (SUB) -> result bytes 01 00 00 80.
